// File: rtl/stereo_pkg.sv
// rtl/stereo_pkg.sv - shared frame geometry, SRAM widths and pixel FIFO entry type
package stereo_pkg;
  localparam int ROW_SZ_DEF = 320;
  localparam int COL_SZ_DEF = 240;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 8;
  localparam int COORD_W    = 10;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WR   = 1'b1
  } wr_state_t;

  // Arithmetic is done modulo 2^ADDR_W, so oversize coordinates wrap rather than saturate.
  function automatic logic [ADDR_W-1:0] pix_addr(input int base, input int row_sz,
                                                 input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return ADDR_W'(base) + ADDR_W'(y) * ADDR_W'(row_sz) + ADDR_W'(x);
  endfunction
endpackage

// File: rtl/frame_writer_if.sv
// rtl/frame_writer_if.sv - pixel strobe input and SRAM write port of frame_writer
interface frame_writer_if;
  import stereo_pkg::*;

  logic [DATA_W-1:0]  in_val;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               is_in_val;
  logic [ADDR_W-1:0]  sram_addr;
  logic [DATA_W-1:0]  sram_wdata;
  logic               sram_write;
  logic               sram_waitrequest;

  modport slave (
    input  in_val, in_x, in_y, is_in_val, sram_waitrequest,
    output sram_addr, sram_wdata, sram_write
  );

  modport master (
    output in_val, in_x, in_y, is_in_val, sram_waitrequest,
    input  sram_addr, sram_wdata, sram_write
  );
endinterface

// File: rtl/frame_writer_pix_fifo.sv
// rtl/frame_writer_pix_fifo.sv - synchronous pixel FIFO with combinational head
module pix_fifo
  import stereo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       pop_i,
  input  pix_entry_t wdata_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       last_one_o,
  output pix_entry_t head_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign last_one_o = (count_q == CW'(1));
  assign head_o     = pix_entry_t'(mem_q[rd_ptr_q]);
endmodule

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - queues filtered pixels and writes them to SRAM at frame addresses
// Optional DROP_OOR_EN: discard strobes whose coordinates fall outside the frame.
module frame_writer
  import stereo_pkg::*;
#(
  parameter int ROW_SZ     = ROW_SZ_DEF,
  parameter int COL_SZ     = COL_SZ_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic           clk,
  input  logic           reset,
  frame_writer_if.slave  bus,
  output logic           frame_done,
  output logic           overflow
);
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(ROW_SZ - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(COL_SZ - 1);

  wr_state_t  state_q, state_d;
  logic       frame_done_q, frame_done_d;
  logic       overflow_q, overflow_d;
  logic       strobe, push, pop, full, empty, last_one;
  pix_entry_t new_entry, head;

`ifdef DROP_OOR_EN
  assign strobe = bus.is_in_val && (32'(bus.in_x) < ROW_SZ) && (32'(bus.in_y) < COL_SZ);
`else
  assign strobe = bus.is_in_val;
`endif

  assign new_entry = '{last: (bus.in_x == LAST_X) && (bus.in_y == LAST_Y),
                       addr: pix_addr(BASE_ADDR, ROW_SZ, bus.in_x, bus.in_y),
                       data: bus.in_val};

  // WR always implies a non-empty FIFO, so a pop never meets an empty queue.
  assign pop  = (state_q == ST_WR) && !bus.sram_waitrequest;
  assign push = strobe && (!full || pop);

  always_comb begin
    state_d      = state_q;
    frame_done_d = pop && head.last;
    overflow_d   = overflow_q | (strobe && full && !pop);
    unique case (state_q)
      ST_IDLE: if (!empty) state_d = ST_WR;
      ST_WR:   if (pop && last_one && !push) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  pix_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (new_entry),
    .full_o     (full),
    .empty_o    (empty),
    .last_one_o (last_one),
    .head_o     (head)
  );

  assign bus.sram_write = (state_q == ST_WR);
  assign bus.sram_addr  = bus.sram_write ? head.addr : '0;
  assign bus.sram_wdata = bus.sram_write ? head.data : '0;
  assign frame_done     = frame_done_q;
  assign overflow       = overflow_q;
endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - directed self-checking bench for frame_writer
module tb_frame_writer;
  logic clk = 1'b0;
  logic reset;
  logic frame_done;
  logic overflow;
  int   n_checks = 0;
  int   n_fail   = 0;

  frame_writer_if bus();

  frame_writer dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int x, input int y, input int d);
    bus.is_in_val = v;
    bus.in_x      = 10'(x);
    bus.in_y      = 10'(y);
    bus.in_val    = 8'(d);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 0, 0, 0);
    bus.sram_waitrequest = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL rst_write: got %b want 0", bus.sram_write); end
    n_checks++; if (bus.sram_addr !== 17'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.sram_addr); end
    n_checks++; if (bus.sram_wdata !== 8'd0) begin n_fail++; $display("FAIL rst_wdata: got %0h want 0", bus.sram_wdata); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.sram_waitrequest = 1'b0;
    drive(1'b1, 5, 2, 8'hA7);
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", bus.sram_write); end
    tick();
    n_checks++; if (bus.sram_write !== 1'b1) begin n_fail++; $display("FAIL single_write: got %b want 1", bus.sram_write); end
    n_checks++; if (bus.sram_addr !== 17'd645) begin n_fail++; $display("FAIL single_addr: got %0d want 645", bus.sram_addr); end
    n_checks++; if (bus.sram_wdata !== 8'hA7) begin n_fail++; $display("FAIL single_wdata: got %0h want a7", bus.sram_wdata); end
    tick();
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL single_once: got %b want 0", bus.sram_write); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL single_frame_done: got %b want 0", frame_done); end
  endtask

  task automatic test_wait();
    bus.sram_waitrequest = 1'b1;
    drive(1'b1, 10, 1, 8'h3C);
    tick();
    drive(1'b0, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({bus.sram_write, bus.sram_addr, bus.sram_wdata} !== {1'b1, 17'd330, 8'h3C}) begin
        n_fail++;
        $display("FAIL wait_hold%0d: got w=%b a=%0d d=%0h want w=1 a=330 d=3c", k, bus.sram_write, bus.sram_addr, bus.sram_wdata);
      end
      tick();
    end
    n_checks++; if (bus.sram_addr !== 17'd330) begin n_fail++; $display("FAIL wait_fifth: got %0d want 330", bus.sram_addr); end
    bus.sram_waitrequest = 1'b0;
    tick();
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL wait_pop: got %b want 0", bus.sram_write); end
  endtask

  task automatic test_overflow();
    bus.sram_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i, 3, 16 + i);
      tick();
    end
    drive(1'b0, 0, 0, 0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    bus.sram_waitrequest = 1'b0;
    for (int i = 0; i < 8; i++) begin
      automatic logic [25:0] e = {1'b1, 17'(960 + i), 8'(16 + i)};
      n_checks++;
      if ({bus.sram_write, bus.sram_addr, bus.sram_wdata} !== e) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got w=%b a=%0d d=%0h want a=%0d d=%0h", i, bus.sram_write, bus.sram_addr, bus.sram_wdata, 960 + i, 16 + i);
      end
      tick();
    end
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got %b want 0", bus.sram_write); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.sram_waitrequest = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i, 4, 64 + i);
      tick();
    end
    drive(1'b1, 8, 4, 72);
    bus.sram_waitrequest = 1'b0;
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf: got %b want 0", overflow); end
    for (int i = 1; i < 9; i++) begin
      automatic logic [25:0] e = {1'b1, 17'(1280 + i), 8'(64 + i)};
      n_checks++;
      if ({bus.sram_write, bus.sram_addr, bus.sram_wdata} !== e) begin
        n_fail++;
        $display("FAIL fullpop_drain%0d: got w=%b a=%0d d=%0h want a=%0d d=%0h", i, bus.sram_write, bus.sram_addr, bus.sram_wdata, 1280 + i, 64 + i);
      end
      tick();
    end
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", bus.sram_write); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf_end: got %b want 0", overflow); end
  endtask

  task automatic test_frame_done();
    bus.sram_waitrequest = 1'b0;
    drive(1'b1, 319, 239, 8'h55);
    tick();
    drive(1'b0, 0, 0, 0);
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL fd_early: got %b want 0", frame_done); end
    tick();
    n_checks++; if (bus.sram_addr !== 17'd76799) begin n_fail++; $display("FAIL fd_addr: got %0d want 76799", bus.sram_addr); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL fd_during: got %b want 0", frame_done); end
    tick();
    n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL fd_pulse: got %b want 1", frame_done); end
    tick();
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL fd_single: got %b want 0", frame_done); end
  endtask

  task automatic test_reset_mid();
    bus.sram_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i, 5, 96 + i);
      tick();
    end
    drive(1'b0, 0, 0, 0);
    n_checks++; if (bus.sram_write !== 1'b1) begin n_fail++; $display("FAIL mid_inwr: got %b want 1", bus.sram_write); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL mid_write: got %b want 0", bus.sram_write); end
    n_checks++; if (bus.sram_addr !== 17'd0) begin n_fail++; $display("FAIL mid_addr: got %0d want 0", bus.sram_addr); end
    tick();
    tick();
    reset = 1'b0;
    bus.sram_waitrequest = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL mid_stale%0d: got %b want 0", k, bus.sram_write); end
    end
    drive(1'b1, 400, 409, 8'h99);
    tick();
    drive(1'b0, 0, 0, 0);
    tick();
`ifdef DROP_OOR_EN
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL oor_dropped: got %b want 0", bus.sram_write); end
    tick();
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL oor_dropped2: got %b want 0", bus.sram_write); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL oor_ovf: got %b want 0", overflow); end
`else
    n_checks++;
    if ({bus.sram_write, bus.sram_addr, bus.sram_wdata} !== {1'b1, 17'd208, 8'h99}) begin
      n_fail++;
      $display("FAIL oor_trunc: got w=%b a=%0d d=%0h want w=1 a=208 d=99", bus.sram_write, bus.sram_addr, bus.sram_wdata);
    end
    tick();
    n_checks++; if (bus.sram_write !== 1'b0) begin n_fail++; $display("FAIL oor_once: got %b want 0", bus.sram_write); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait();
    test_overflow();
    test_full_pop();
    test_frame_done();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 The block SHALL have parameter ROW_SZ, default 320, meaning pixels per row.
REQ-002 The block SHALL have parameter COL_SZ, default 240, meaning rows per frame.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning entries in the pixel FIFO (power of two, at least 2).
REQ-004 The block SHALL have parameter BASE_ADDR, default 0, meaning the word address of pixel (0,0).
REQ-005 The block SHALL run on one clock, clk (input, 1 bit); reset is asynchronous and active-high.
REQ-006 Port reset  input  1  asynchronous active-high reset.
REQ-007 Port in_val  input  8  filtered pixel value from median_filt out_val.
REQ-008 Port in_x  input  10  pixel column from median_filt out_x.
REQ-009 Port in_y  input  10  pixel row from median_filt out_y.
REQ-010 Port is_in_val  input  1  single-cycle pixel strobe from median_filt is_out_val; there is no backpressure.
REQ-011 Port sram_addr  output  17  word write address.
REQ-012 Port sram_wdata  output  8  write data.
REQ-013 Port sram_write  output  1  write request, held until accepted.
REQ-014 Port sram_waitrequest  input  1  slave stall; a write is accepted in a cycle where sram_write=1 and sram_waitrequest=0.
REQ-015 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-016 Port overflow  output  1  sticky flag set when a pixel is dropped because the FIFO is full.

Function
REQ-017 Address arithmetic SHALL be sram_addr = BASE_ADDR + in_y*ROW_SZ + in_x, computed at push and truncated to 17 bits.
REQ-018 Each FIFO entry SHALL hold {addr[16:0], data[7:0]}.
REQ-019 A strobe with the FIFO not full SHALL push that cycle; the entry becomes visible at the FIFO head on the next edge.
REQ-020 A strobe with the FIFO full and no pop in the same cycle SHALL be dropped and SHALL set overflow; overflow stays set until reset.
REQ-021 A strobe with the FIFO full and a pop in the same cycle SHALL be accepted, and the occupancy SHALL stay at FIFO_DEPTH.
REQ-022 The FSM SHALL have two states: IDLE, where sram_write=0, and WR, where sram_write=1 and sram_addr/sram_wdata show the FIFO head.
REQ-023 In IDLE with the FIFO non-empty, the FSM SHALL go to WR on the next edge; minimum latency from strobe to sram_write=1 is 2 cycles.
REQ-024 In WR with sram_waitrequest=1, the FSM SHALL hold, and address and data SHALL stay stable.
REQ-025 In WR with sram_waitrequest=0, the FSM SHALL pop the head; it stays in WR if entries remain, otherwise it returns to IDLE.
REQ-026 Back-to-back accepts SHALL sustain one write per cycle.
REQ-027 frame_done SHALL pulse for exactly one cycle, on the cycle after acceptance of the entry whose source coordinates were (ROW_SZ-1, COL_SZ-1).
REQ-028 Each entry SHALL carry a 1-bit last flag so that REQ-027 does not require decoding the address.
REQ-029 With the FIFO empty, push and pop SHALL never coincide; empty-to-non-empty goes through REQ-023.

Reset
REQ-030 Asserting reset, including mid-write, SHALL force sram_write=0, frame_done=0, overflow=0, FSM=IDLE and the FIFO empty.
REQ-031 Asserting reset SHALL force sram_addr=0 and sram_wdata=0; queued pixels are discarded.
REQ-032 After reset deasserts, the first strobe SHALL be handled as in an empty-FIFO state.

Configuration
REQ-033 With DROP_OOR_EN defined, a strobe with in_x>=ROW_SZ or in_y>=COL_SZ SHALL not be pushed and SHALL not set overflow.
REQ-034 Without DROP_OOR_EN, every strobe SHALL be pushed using the truncated address of REQ-017.

Structure
REQ-035 ROW_SZ/COL_SZ defaults, ADDR_W=17 and the FIFO entry width SHALL live in shared package stereo_pkg.
REQ-036 The FIFO SHALL be a separate sub-module pix_fifo: synchronous, with push, pop, full, empty and head outputs.
REQ-037 The FSM and address computation SHALL be in frame_writer.

Verification
REQ-038 Strobe (x=5, y=2, val=0xA7), waitrequest=0 -> sram_write high 2 cycles later, addr=645, wdata=0xA7, one cycle only.
REQ-039 Strobe while waitrequest=1 for 4 cycles -> addr/wdata stable 4 cycles, popped on the 5th.
REQ-040 10 consecutive strobes, waitrequest stuck at 1, FIFO_DEPTH=8 -> 8 entries retained; pixels 9 and 10 dropped; overflow=1; the 8 writes emerge in order after release.
REQ-041 Full FIFO with strobe and pop in the same cycle -> strobe accepted, overflow stays 0.
REQ-042 Strobe at (319,239) with waitrequest=0 -> addr=76799; frame_done pulses exactly once, one cycle after acceptance.
REQ-043 Reset asserted while in WR with 3 entries queued -> sram_write=0 immediately; after release no stale writes; x=400 dropped with DROP_OOR_EN, written with addr truncated without it.
